// File: rtl/csh_cyc_arb.sv
// Cache cycle arbiter for the MBOX: grants EBOX/channel/CCA cache cycles and
// sequences each one through lookup, writeback, fill or page-table refill.
module csh_cyc_arb #(
    parameter int WB_CYCLES  = 4,
    parameter int STARVE_LIM = 4
) (
    input  logic       clk_mbox_h,
    input  logic       mr_reset_l,
    input  logic       ebox_req_h,
    input  logic       chan_req_h,
    input  logic       cca_req_h,
    input  logic       pag_refill_req_h,
    input  logic       csh_hit_h,
    input  logic       victim_dirty_h,
    input  logic       mem_done_h,
    output logic       ebox_grant_h,
    output logic       chan_grant_h,
    output logic       cca_grant_h,
    output logic [2:0] pma_src_h,
    output logic       cyc_type_hold_h,
    output logic       csh_ebox_cyc_l,
    output logic       csh_writeback_cyc_h,
    output logic       page_refill_cyc_l,
    output logic       ready_to_go_l,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        WB     = 3'd2,
        FILL   = 3'd3,
        REFILL = 3'd4,
        DONE   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OWN_EBOX = 2'd0,
        OWN_CHAN = 2'd1,
        OWN_CCA  = 2'd2
    } owner_t;

    localparam logic [2:0] SRC_VMA = 3'd0;
    localparam logic [2:0] SRC_CCW = 3'd1;
    localparam logic [2:0] SRC_CAM = 3'd2;
    localparam logic [2:0] SRC_PT  = 3'd3;
    localparam logic [2:0] SRC_WB  = 3'd4;

    localparam logic [3:0] WB_LAST  = 4'(WB_CYCLES - 1);
    localparam logic [3:0] STARVE_M = 4'(STARVE_LIM);

    state_t     state;
    owner_t     owner;
    owner_t     winner;
    state_t     lookup_next;
    logic [3:0] starve_cnt;
    logic [3:0] wb_cnt;
    logic       refill_done;
    logic       any_req;

    assign state_dbg = state;
    assign any_req   = ebox_req_h | chan_req_h | cca_req_h;

    function automatic logic [2:0] src_of(input owner_t o);
        case (o)
            OWN_CHAN: src_of = SRC_CCW;
            OWN_CCA:  src_of = SRC_CAM;
            default:  src_of = SRC_VMA;
        endcase
    endfunction

    // A starved EBOX overrides the fixed chan > cca > ebox order.
    always_comb begin
        winner = OWN_EBOX;
        if (ebox_req_h && (starve_cnt == STARVE_M)) begin
            winner = OWN_EBOX;
        end else if (chan_req_h) begin
            winner = OWN_CHAN;
        end else if (cca_req_h) begin
            winner = OWN_CCA;
        end
    end

    always_comb begin
        lookup_next = DONE;
        if (owner == OWN_CCA) begin
            lookup_next = (csh_hit_h && victim_dirty_h) ? WB : DONE;
        end else if ((owner == OWN_EBOX) && pag_refill_req_h && !refill_done) begin
            lookup_next = REFILL;
        end else if (csh_hit_h) begin
            lookup_next = DONE;
        end else if (victim_dirty_h) begin
            lookup_next = WB;
        end else begin
            lookup_next = FILL;
        end
    end

    always_ff @(posedge clk_mbox_h) begin
        if (!mr_reset_l) begin
            state               <= IDLE;
            owner               <= OWN_EBOX;
            starve_cnt          <= 4'd0;
            wb_cnt              <= 4'd0;
            refill_done         <= 1'b0;
            ebox_grant_h        <= 1'b0;
            chan_grant_h        <= 1'b0;
            cca_grant_h         <= 1'b0;
            pma_src_h           <= SRC_VMA;
            cyc_type_hold_h     <= 1'b0;
            csh_ebox_cyc_l      <= 1'b1;
            csh_writeback_cyc_h <= 1'b0;
            page_refill_cyc_l   <= 1'b1;
            ready_to_go_l       <= 1'b1;
        end else begin
            ebox_grant_h  <= 1'b0;
            chan_grant_h  <= 1'b0;
            cca_grant_h   <= 1'b0;
            ready_to_go_l <= 1'b1;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state           <= LOOKUP;
                        owner           <= winner;
                        ebox_grant_h    <= (winner == OWN_EBOX);
                        chan_grant_h    <= (winner == OWN_CHAN);
                        cca_grant_h     <= (winner == OWN_CCA);
                        pma_src_h       <= src_of(winner);
                        cyc_type_hold_h <= 1'b1;
                        csh_ebox_cyc_l  <= (winner != OWN_EBOX);
                        if (!ebox_req_h || (winner == OWN_EBOX)) begin
                            starve_cnt <= 4'd0;
                        end else begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end
                end
                LOOKUP: begin
                    state <= lookup_next;
                    case (lookup_next)
                        WB: begin
                            pma_src_h           <= SRC_WB;
                            csh_writeback_cyc_h <= 1'b1;
                            wb_cnt              <= 4'd0;
                        end
                        REFILL: begin
                            pma_src_h         <= SRC_PT;
                            page_refill_cyc_l <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                WB: begin
                    if (wb_cnt == WB_LAST) begin
                        csh_writeback_cyc_h <= 1'b0;
                        pma_src_h           <= src_of(owner);
                        state               <= (owner == OWN_CCA) ? DONE : FILL;
                    end else begin
                        wb_cnt <= wb_cnt + 4'd1;
                    end
                end
                FILL: begin
                    if (mem_done_h) begin
                        state <= DONE;
                    end
                end
                REFILL: begin
                    // The page table entry is in; retry the lookup exactly once.
                    if (mem_done_h) begin
                        state             <= LOOKUP;
                        refill_done       <= 1'b1;
                        page_refill_cyc_l <= 1'b1;
                        pma_src_h         <= src_of(owner);
                    end
                end
                DONE: begin
                    state           <= IDLE;
                    ready_to_go_l   <= 1'b0;
                    pma_src_h       <= SRC_VMA;
                    cyc_type_hold_h <= 1'b0;
                    csh_ebox_cyc_l  <= 1'b1;
                    refill_done     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csh_cyc_arb.sv
// Bench for csh_cyc_arb: hand-checked cycle table, reset/starvation/writeback
// abort sequences, and random cycles checked against a phase-list model.
module tb_csh_cyc_arb;

    localparam int WB = 4;
    localparam int SL = 4;

    localparam logic [2:0] S_ID = 3'd0;
    localparam logic [2:0] S_LK = 3'd1;
    localparam logic [2:0] S_WB = 3'd2;
    localparam logic [2:0] S_FL = 3'd3;
    localparam logic [2:0] S_RF = 3'd4;
    localparam logic [2:0] S_DN = 3'd5;

    logic       clk_mbox_h = 1'b0;
    logic       mr_reset_l = 1'b0;
    logic       ebox_req_h = 1'b0;
    logic       chan_req_h = 1'b0;
    logic       cca_req_h = 1'b0;
    logic       pag_refill_req_h = 1'b0;
    logic       csh_hit_h = 1'b0;
    logic       victim_dirty_h = 1'b0;
    logic       mem_done_h = 1'b0;
    logic       ebox_grant_h, chan_grant_h, cca_grant_h;
    logic [2:0] pma_src_h;
    logic       cyc_type_hold_h, csh_ebox_cyc_l, csh_writeback_cyc_h;
    logic       page_refill_cyc_l, ready_to_go_l;
    logic [2:0] state_dbg;

    csh_cyc_arb #(.WB_CYCLES(WB), .STARVE_LIM(SL)) dut (
        .clk_mbox_h(clk_mbox_h), .mr_reset_l(mr_reset_l),
        .ebox_req_h(ebox_req_h), .chan_req_h(chan_req_h), .cca_req_h(cca_req_h),
        .pag_refill_req_h(pag_refill_req_h), .csh_hit_h(csh_hit_h),
        .victim_dirty_h(victim_dirty_h), .mem_done_h(mem_done_h),
        .ebox_grant_h(ebox_grant_h), .chan_grant_h(chan_grant_h), .cca_grant_h(cca_grant_h),
        .pma_src_h(pma_src_h), .cyc_type_hold_h(cyc_type_hold_h),
        .csh_ebox_cyc_l(csh_ebox_cyc_l), .csh_writeback_cyc_h(csh_writeback_cyc_h),
        .page_refill_cyc_l(page_refill_cyc_l), .ready_to_go_l(ready_to_go_l),
        .state_dbg(state_dbg)
    );

    always #5 clk_mbox_h = ~clk_mbox_h;

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] gnt;
        logic [2:0] src;
        logic       hold;
        logic       e_l;
        logic       wb;
        logic       rf_l;
        logic       rdy_l;
    } outv_t;

    typedef struct packed {
        outv_t o;
        logic  md;
        logic  noise;
    } cyc_t;

    typedef struct {
        int owner;
        int src;
        int lat;
        int wb;
        int rf;
    } obs_t;

    typedef struct {
        bit c, a, e, h, d, p;
        int k, j;
        int x_owner, x_src, x_lat, x_wb, x_rf;
    } vec_t;

    localparam outv_t RST_V = '{st: 3'd0, gnt: 3'd0, src: 3'd0, hold: 1'b0,
                                e_l: 1'b1, wb: 1'b0, rf_l: 1'b1, rdy_l: 1'b1};

    logic [15:0] exp_q[$];
    int n_vec = 0;
    int n_bad = 0;
    int starve_m = 0;

    function automatic outv_t actual();
        return {state_dbg, cca_grant_h, chan_grant_h, ebox_grant_h, pma_src_h,
                cyc_type_hold_h, csh_ebox_cyc_l, csh_writeback_cyc_h,
                page_refill_cyc_l, ready_to_go_l};
    endfunction

    task automatic check_i(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_v(input string name, input outv_t act, input outv_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got st=%0d gnt=%b src=%0d hold=%b e_l=%b wb=%b rf_l=%b rdy_l=%b, expected st=%0d gnt=%b src=%0d hold=%b e_l=%b wb=%b rf_l=%b rdy_l=%b",
                     name, $time, act.st, act.gnt, act.src, act.hold, act.e_l, act.wb, act.rf_l, act.rdy_l,
                     exp.st, exp.gnt, exp.src, exp.hold, exp.e_l, exp.wb, exp.rf_l, exp.rdy_l);
        end
    endtask

    task automatic push(input logic [2:0] st, input logic [2:0] gnt, input logic [2:0] src,
                        input logic hold, input logic e_l, input logic wb, input logic rf_l,
                        input logic rdy_l, input logic md, input logic nz);
        cyc_t c;
        c.o = '{st: st, gnt: gnt, src: src, hold: hold, e_l: e_l, wb: wb, rf_l: rf_l, rdy_l: rdy_l};
        c.md = md;
        c.noise = nz;
        exp_q.push_back(16'(c));
    endtask

    // Owner numbering matches the address source code: 0 ebox/VMA, 1 chan/CCW, 2 cca/CAM.
    function automatic int pick(input bit c, input bit a, input bit e);
        if (e && starve_m == SL) return 0;
        if (c) return 1;
        if (a) return 2;
        if (e) return 0;
        return -1;
    endfunction

    // Expected per-clock outputs of one cache cycle, from grant to the ready pulse.
    task automatic plan(input int own, input bit h, input bit d, input bit p, input int k, input int j);
        logic [2:0] s, g;
        logic el;
        s  = 3'(own);
        g  = 3'b001 << own;
        el = (own != 0);
        push(S_LK, g, s, 1, el, 0, 1, 1, 0, 1);
        if (own == 0 && p) begin
            for (int i = 0; i < j; i++) push(S_RF, 3'd0, 3'd3, 1, el, 0, 0, 1, (i == j - 1), 0);
            push(S_LK, 3'd0, s, 1, el, 0, 1, 1, 0, 1);
        end
        if ((own == 2) ? (h && d) : (!h && d)) begin
            for (int i = 0; i < WB; i++) push(S_WB, 3'd0, 3'd4, 1, el, 1, 1, 1, 0, 1);
        end
        if (own != 2 && !h) begin
            for (int i = 0; i < k; i++) push(S_FL, 3'd0, s, 1, el, 0, 1, 1, (i == k - 1), 0);
        end
        push(S_DN, 3'd0, s, 1, el, 0, 1, 1, 0, 1);
        push(S_ID, 3'd0, 3'd0, 0, 1, 0, 1, 0, 0, 1);
    endtask

    // Entered and left during an IDLE clock, after its falling edge.
    task automatic run_txn(input bit c, input bit a, input bit e, input bit h, input bit d,
                           input bit p, input int k, input int j, output obs_t ob);
        int own, ci, gi;
        cyc_t x;
        outv_t act;
        ob = '{owner: -1, src: -1, lat: -1, wb: 0, rf: 0};
        chan_req_h = c; cca_req_h = a; ebox_req_h = e;
        csh_hit_h = h; victim_dirty_h = d; pag_refill_req_h = p;
        mem_done_h = 1'($urandom_range(0, 1));
        own = pick(c, a, e);
        if (own < 0) begin
            push(S_ID, 3'd0, 3'd0, 0, 1, 0, 1, 1, 0, 1);
        end else begin
            if (!e || own == 0) starve_m = 0;
            else starve_m++;
            plan(own, h, d, p, k, j);
        end
        ci = 0;
        gi = -1;
        while (exp_q.size() > 0) begin
            @(posedge clk_mbox_h); #1;
            x = cyc_t'(exp_q.pop_front());
            mem_done_h = x.md | (x.noise & 1'($urandom_range(0, 1)));
            if (x.o.st == S_ID) {chan_req_h, cca_req_h, ebox_req_h} = 3'b000;
            else {chan_req_h, cca_req_h, ebox_req_h} = 3'($urandom_range(0, 7));
            if (x.o.st == S_LK) begin
                csh_hit_h = h; victim_dirty_h = d; pag_refill_req_h = p;
            end else begin
                {csh_hit_h, victim_dirty_h, pag_refill_req_h} = 3'($urandom_range(0, 7));
            end
            @(negedge clk_mbox_h);
            act = actual();
            check_v("cycle", act, x.o);
            if (act.gnt != 3'd0 && ob.owner < 0) begin
                ob.owner = (act.gnt == 3'b001) ? 0 : (act.gnt == 3'b010) ? 1 : (act.gnt == 3'b100) ? 2 : -2;
                ob.src   = int'(act.src);
                gi       = ci;
            end
            if (act.wb) ob.wb++;
            if (!act.rf_l) ob.rf++;
            if (!act.rdy_l && gi >= 0 && ob.lat < 0) ob.lat = ci - gi;
            ci++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk_mbox_h); #1;
        mr_reset_l = 1'b0;
        {chan_req_h, cca_req_h, ebox_req_h} = 3'($urandom_range(0, 7));
        repeat (2) @(posedge clk_mbox_h);
        @(negedge clk_mbox_h);
        check_v("reset_hold", actual(), RST_V);
        @(posedge clk_mbox_h); #1;
        mr_reset_l = 1'b1;
        {chan_req_h, cca_req_h, ebox_req_h, csh_hit_h, victim_dirty_h, pag_refill_req_h, mem_done_h} = 7'd0;
        @(negedge clk_mbox_h);
        check_v("reset_release", actual(), RST_V);
        starve_m = 0;
    endtask

    vec_t tbl[9];
    int starve_own[6];
    obs_t ob;

    initial begin
        //           c  a  e  h  d  p  k  j  own src lat wb rf
        tbl[0] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 2, 0, 0};
        tbl[1] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 2, 0, 0};
        tbl[2] = '{0, 0, 1, 0, 1, 0, 3, 1, 0, 0, 9, 4, 0};
        tbl[3] = '{0, 0, 1, 1, 0, 1, 1, 2, 0, 0, 5, 0, 2};
        tbl[4] = '{0, 1, 0, 1, 0, 0, 1, 1, 2, 2, 2, 0, 0};
        tbl[5] = '{0, 1, 0, 0, 1, 0, 1, 1, 2, 2, 2, 0, 0};
        tbl[6] = '{0, 1, 0, 1, 1, 0, 1, 1, 2, 2, 6, 4, 0};
        tbl[7] = '{1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 3, 0, 0};
        tbl[8] = '{0, 1, 1, 0, 0, 0, 2, 1, 2, 2, 2, 0, 0};
        starve_own = '{1, 1, 1, 1, 0, 1};

        do_reset();

        for (int i = 0; i < 9; i++) begin
            run_txn(tbl[i].c, tbl[i].a, tbl[i].e, tbl[i].h, tbl[i].d, tbl[i].p, tbl[i].k, tbl[i].j, ob);
            check_i($sformatf("tbl%0d_owner", i), ob.owner, tbl[i].x_owner);
            check_i($sformatf("tbl%0d_src", i), ob.src, tbl[i].x_src);
            check_i($sformatf("tbl%0d_lat", i), ob.lat, tbl[i].x_lat);
            check_i($sformatf("tbl%0d_wb", i), ob.wb, tbl[i].x_wb);
            check_i($sformatf("tbl%0d_rf", i), ob.rf, tbl[i].x_rf);
        end

        // Channel hogging the cache: EBOX must break through after four losses.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            run_txn(1, 0, 1, 1, 0, 0, 1, 1, ob);
            check_i($sformatf("starve%0d_owner", i), ob.owner, starve_own[i]);
        end

        // Reset in the middle of a writeback aborts without a ready pulse.
        {chan_req_h, cca_req_h, ebox_req_h} = 3'b001;
        csh_hit_h = 1'b0; victim_dirty_h = 1'b1; pag_refill_req_h = 1'b0; mem_done_h = 1'b0;
        @(posedge clk_mbox_h); #1;
        ebox_req_h = 1'b0;
        @(negedge clk_mbox_h);
        check_i("wbrst_grant", int'(ebox_grant_h), 1);
        @(posedge clk_mbox_h); #1;
        @(negedge clk_mbox_h);
        check_i("wbrst_wb1", int'({csh_writeback_cyc_h, pma_src_h}), 12);
        @(posedge clk_mbox_h); #1;
        mr_reset_l = 1'b0;
        @(negedge clk_mbox_h);
        check_i("wbrst_wb2", int'({csh_writeback_cyc_h, pma_src_h}), 12);
        @(posedge clk_mbox_h); #1;
        mr_reset_l = 1'b1;
        @(negedge clk_mbox_h);
        check_v("wbrst_abort", actual(), RST_V);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_mbox_h); #1;
            mem_done_h = 1'($urandom_range(0, 1));
            @(negedge clk_mbox_h);
            check_v("wbrst_idle", actual(), RST_V);
        end
        mem_done_h = 1'b0;
        starve_m = 0;

        for (int i = 0; i < 80; i++) begin
            run_txn($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
                    $urandom_range(1, 4), $urandom_range(1, 3), ob);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
